// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: two-stage SECDED (extended Hamming) check/correct stage with saturating error counters.
// Define ECC_ERR_INJECT_EN to add the inj_en/inj_mask error-injection ports.
module ecc_secded_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic [PARITY_WIDTH-1:0]              in_parity,
  input  logic                                 in_bypass,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_sbit_err,
  output logic                                 out_dbit_err,
  output logic [PARITY_WIDTH-1:0]              out_syndrome,
`ifdef ECC_ERR_INJECT_EN
  input  logic                                 inj_en,
  input  logic [DATA_WIDTH+PARITY_WIDTH-1:0]   inj_mask,
`endif
  input  logic                                 cnt_clr,
  output logic [CNT_WIDTH-1:0]                 sbit_cnt,
  output logic [CNT_WIDTH-1:0]                 dbit_cnt
);

  localparam int SW   = PARITY_WIDTH - 1;
  localparam int NPOS = DATA_WIDTH + PARITY_WIDTH - 1;
  localparam logic [SW-1:0] MAX_POS = SW'(NPOS);

  // Low check bits equal the XOR of the Hamming positions of all set data bits.
  function automatic logic [PARITY_WIDTH-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] data);
    logic [DATA_WIDTH-1:0] d;
    logic [SW-1:0]         p;
    d = data;
    p = '0;
    for (int pos = 1; pos <= NPOS; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        p = p ^ (SW'(pos) & {SW{d[0]}});
        d = d >> 1;
      end
    end
    return {(^data) ^ (^p), p};
  endfunction

  // The overall bit is the parity of the whole received codeword, so it tracks the error count.
  function automatic logic [PARITY_WIDTH-1:0] ecc_syndrome(input logic [DATA_WIDTH-1:0]   data,
                                                           input logic [PARITY_WIDTH-1:0] parity);
    logic [PARITY_WIDTH-1:0] rec;
    rec = ecc_encode(data);
    return {^{parity, data}, rec[SW-1:0] ^ parity[SW-1:0]};
  endfunction

  function automatic logic ecc_is_pow2(input logic [SW-1:0] s);
    return (s != '0) && ((s & (s - SW'(1))) == '0);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ecc_flip_mask(input logic [SW-1:0] s);
    logic [DATA_WIDTH-1:0] one_hot;
    logic [DATA_WIDTH-1:0] mask;
    one_hot = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    mask    = '0;
    for (int pos = 1; pos <= NPOS; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        mask    = mask | (one_hot & {DATA_WIDTH{SW'(pos) == s}});
        one_hot = one_hot << 1;
      end
    end
    return mask;
  endfunction

  logic                    s1_valid_r;
  logic                    s1_bypass_r;
  logic [DATA_WIDTH-1:0]   s1_data_r;
  logic [PARITY_WIDTH-1:0] s1_syn_r;

  logic [DATA_WIDTH-1:0]   dec_data_s;
  logic [PARITY_WIDTH-1:0] dec_parity_s;
  logic                    s2_adv_s;
  logic                    out_hs_s;
  logic [SW-1:0]           syn_pos_s;
  logic                    syn_ov_s;
  logic [DATA_WIDTH-1:0]   fix_data_s;
  logic                    sbit_s;
  logic                    dbit_s;

  assign s2_adv_s = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid_r || s2_adv_s);
  assign out_hs_s = out_valid && out_ready;

  // Select the codeword to decode (optionally corrupted for test).
  always_comb begin
`ifdef ECC_ERR_INJECT_EN
    if (inj_en && !in_bypass) begin
      {dec_parity_s, dec_data_s} = {in_parity, in_data} ^ inj_mask;
    end else begin
      {dec_parity_s, dec_data_s} = {in_parity, in_data};
    end
`else
    {dec_parity_s, dec_data_s} = {in_parity, in_data};
`endif
  end

  // Stage 1: capture the word and its syndrome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_bypass_r <= 1'b0;
      s1_data_r   <= '0;
      s1_syn_r    <= '0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_bypass_r <= in_bypass;
        s1_data_r   <= dec_data_s;
        s1_syn_r    <= in_bypass ? '0 : ecc_syndrome(dec_data_s, dec_parity_s);
      end else begin
        s1_bypass_r <= s1_bypass_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Classify the syndrome and build the corrected word.
  always_comb begin
    syn_pos_s  = s1_syn_r[SW-1:0];
    syn_ov_s   = s1_syn_r[PARITY_WIDTH-1];
    fix_data_s = s1_data_r;
    sbit_s     = 1'b0;
    dbit_s     = 1'b0;
    if (s1_bypass_r) begin
      fix_data_s = s1_data_r;
    end else if (!syn_ov_s) begin
      dbit_s = (syn_pos_s != '0);
    end else if (syn_pos_s == '0 || ecc_is_pow2(syn_pos_s)) begin
      sbit_s = 1'b1;
    end else if (syn_pos_s > MAX_POS) begin
      dbit_s = 1'b1;
    end else begin
      sbit_s     = 1'b1;
      fix_data_s = s1_data_r ^ ecc_flip_mask(syn_pos_s);
    end
  end

  // Stage 2: output register, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sbit_err <= 1'b0;
      out_dbit_err <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data     <= fix_data_s;
        out_sbit_err <= sbit_s;
        out_dbit_err <= dbit_s;
        out_syndrome <= s1_syn_r;
      end else begin
        out_data <= out_data;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

  // Saturating error counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
    end else if (cnt_clr) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
    end else begin
      if (out_hs_s && out_sbit_err && sbit_cnt != '1) begin
        sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
      end else begin
        sbit_cnt <= sbit_cnt;
      end
      if (out_hs_s && out_dbit_err && dbit_cnt != '1) begin
        dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
      end else begin
        dbit_cnt <= dbit_cnt;
      end
    end
  end

endmodule
